// File: rtl/vreg_wb_arbiter_pkg.sv
// Shared types and default widths for the vector register write-back arbiter.
package vreg_wb_arbiter_pkg;

  localparam int unsigned VWB_DATA_W  = 128;
  localparam int unsigned VWB_ADDR_W  = 5;
  localparam int unsigned VWB_ELEMS_W = 2;
  localparam int unsigned VWB_CNT_W   = 16;

  // One write-back request as seen by vector_registers.
  typedef struct packed {
    logic [VWB_ADDR_W-1:0]  addr;
    logic [VWB_DATA_W-1:0]  data;
    logic [VWB_ELEMS_W-1:0] elems;
    logic                   widen;
  } vreg_wb_req_t;

  localparam int unsigned VWB_REQ_W = $bits(vreg_wb_req_t);

  // Write-back source identifiers.
  typedef enum logic {
    WB_SRC_ARITH = 1'b0,
    WB_SRC_LSU   = 1'b1
  } wb_src_t;

endpackage

// File: rtl/vreg_wb_arbiter_slot.sv
// One-entry valid/ready holding register for a single write-back source.
module vreg_wb_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         valid,
  input  logic [W-1:0] din,
  input  logic         free,
  output logic         ready,
  output logic         load,
  output logic         full,
  output logic [W-1:0] dout
);

  logic         full_q;
  logic [W-1:0] data_q;

  // A slot being drained this cycle can take a new entry at the same edge.
  assign ready = ~full_q | free;
  assign load  = valid & ready;
  assign full  = full_q;
  assign dout  = data_q;

  // Slot state: flush wins over load, load wins over free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (flush) begin
      full_q <= 1'b0;
    end else if (load) begin
      full_q <= 1'b1;
      data_q <= din;
    end else if (free) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/vreg_wb_arbiter.sv
// Oldest-first arbiter for the single vector register file write port.
module vreg_wb_arbiter
  import vreg_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = VWB_DATA_W,
  parameter int unsigned ADDR_W = VWB_ADDR_W,
  parameter int unsigned CNT_W  = VWB_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              arith_valid_i,
  output logic              arith_ready_o,
  input  logic [ADDR_W-1:0] arith_addr_i,
  input  logic [DATA_W-1:0] arith_data_i,
  input  logic [1:0]        arith_elems_i,
  input  logic              arith_widen_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  input  logic [1:0]        lsu_elems_i,
  input  logic              lsu_widen_i,
  output logic              vreg_we_o,
  output logic [ADDR_W-1:0] vreg_addr_o,
  output logic [DATA_W-1:0] vreg_data_o,
  output logic [1:0]        vreg_elems_o,
  output logic              vreg_widen_o,
  output logic              idle_o,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  localparam int unsigned PAY_W = ADDR_W + DATA_W + 2 + 1;

  logic [PAY_W-1:0] a_din, l_din, a_pay, l_pay, out_pay_q;
  logic             a_full, l_full, a_load, l_load;
  logic             grant_a, grant_l;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;
  wb_src_t          age_q, age_d, last_q, last_d;

  assign a_din = {arith_addr_i, arith_data_i, arith_elems_i, arith_widen_i};
  assign l_din = {lsu_addr_i, lsu_data_i, lsu_elems_i, lsu_widen_i};

  // Grant from registered state only: sole full slot, else the older one.
  assign grant_a = a_full & (~l_full | (age_q == WB_SRC_ARITH));
  assign grant_l = l_full & (~a_full | (age_q == WB_SRC_LSU));

  vreg_wb_slot #(.W(PAY_W)) u_arith_slot (
    .clk   (clk),
    .reset (reset),
    .flush (flush_i),
    .valid (arith_valid_i),
    .din   (a_din),
    .free  (grant_a),
    .ready (arith_ready_o),
    .load  (a_load),
    .full  (a_full),
    .dout  (a_pay)
  );

  vreg_wb_slot #(.W(PAY_W)) u_lsu_slot (
    .clk   (clk),
    .reset (reset),
    .flush (flush_i),
    .valid (lsu_valid_i),
    .din   (l_din),
    .free  (grant_l),
    .ready (lsu_ready_o),
    .load  (l_load),
    .full  (l_full),
    .dout  (l_pay)
  );

  // Next age / last-grant: a new entry is younger than one still waiting; simultaneous loads round-robin.
  always_comb begin
    age_d  = age_q;
    last_d = last_q;
    if (!flush_i) begin
      if (grant_a) begin
        last_d = WB_SRC_ARITH;
      end else if (grant_l) begin
        last_d = WB_SRC_LSU;
      end
      if (a_load && l_load) begin
        age_d = (last_q == WB_SRC_ARITH) ? WB_SRC_LSU : WB_SRC_ARITH;
      end else if (a_load && l_full && !grant_l) begin
        age_d = WB_SRC_LSU;
      end else if (l_load && a_full && !grant_a) begin
        age_d = WB_SRC_ARITH;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age_q  <= WB_SRC_ARITH;
      last_q <= WB_SRC_LSU;
    end else begin
      age_q  <= age_d;
      last_q <= last_d;
    end
  end

  // Registered write port; fields hold when no grant is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b0;
      out_pay_q <= '0;
    end else if (flush_i) begin
      we_q <= 1'b0;
    end else begin
      we_q <= grant_a | grant_l;
      if (grant_a) begin
        out_pay_q <= a_pay;
      end else if (grant_l) begin
        out_pay_q <= l_pay;
      end
    end
  end

  // Saturating count of cycles with both slots occupied; frozen during flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!flush_i && a_full && l_full && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign vreg_we_o = we_q;
  assign {vreg_addr_o, vreg_data_o, vreg_elems_o, vreg_widen_o} = out_pay_q;
  assign idle_o         = ~a_full & ~l_full & ~we_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Randomized and directed bench for vreg_wb_arbiter against a queue-based age-order model.
module tb_vreg_wb_arbiter;
  import vreg_wb_arbiter_pkg::*;

  logic clk;
  logic reset;
  logic flush;
  logic a_v, l_v;
  vreg_wb_req_t a_req, l_req;
  logic a_rdy, l_rdy;
  logic we;
  logic [VWB_ADDR_W-1:0] waddr;
  logic [VWB_DATA_W-1:0] wdata;
  logic [1:0] welems;
  logic wwiden;
  logic idle;
  logic [VWB_CNT_W-1:0] cnt;

  int total;
  int bad;

  // Model: pending entry per source, age-ordered queue of waiting sources.
  vreg_wb_req_t m_pend [2];
  bit           m_full [2];
  int           m_q [$];
  bit           m_we;
  vreg_wb_req_t m_out;
  int           m_last;
  logic [15:0]  m_cnt;
  logic [127:0] rf [32];

  vreg_wb_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (flush),
    .arith_valid_i  (a_v),
    .arith_ready_o  (a_rdy),
    .arith_addr_i   (a_req.addr),
    .arith_data_i   (a_req.data),
    .arith_elems_i  (a_req.elems),
    .arith_widen_i  (a_req.widen),
    .lsu_valid_i    (l_v),
    .lsu_ready_o    (l_rdy),
    .lsu_addr_i     (l_req.addr),
    .lsu_data_i     (l_req.data),
    .lsu_elems_i    (l_req.elems),
    .lsu_widen_i    (l_req.widen),
    .vreg_we_o      (we),
    .vreg_addr_o    (waddr),
    .vreg_data_o    (wdata),
    .vreg_elems_o   (welems),
    .vreg_widen_o   (wwiden),
    .idle_o         (idle),
    .conflict_cnt_o (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic vreg_wb_req_t rand_req(input logic [4:0] addr);
    vreg_wb_req_t r;
    r.addr  = addr;
    r.data  = {$urandom, $urandom, $urandom, $urandom};
    r.elems = 2'($urandom_range(0, 3));
    r.widen = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic void model_reset();
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    m_q.delete();
    m_we   = 1'b0;
    m_out  = '0;
    m_last = 1;
    m_cnt  = '0;
  endfunction

  function automatic int model_head();
    return (m_q.size() > 0) ? m_q[0] : -1;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  function automatic void model_step();
    int  g;
    int  lb;
    bit  ra, rl, la, ll, both;
    g    = model_head();
    lb   = m_last;
    ra   = !m_full[0] || (g == 0);
    rl   = !m_full[1] || (g == 1);
    both = (m_q.size() == 2);
    if (flush) begin
      m_full[0] = 1'b0;
      m_full[1] = 1'b0;
      m_q.delete();
      m_we = 1'b0;
    end else begin
      if (g >= 0) begin
        m_out     = m_pend[g];
        m_we      = 1'b1;
        m_full[g] = 1'b0;
        void'(m_q.pop_front());
        m_last    = g;
      end else begin
        m_we = 1'b0;
      end
      la = a_v && ra;
      ll = l_v && rl;
      if (la) begin m_pend[0] = a_req; m_full[0] = 1'b1; end
      if (ll) begin m_pend[1] = l_req; m_full[1] = 1'b1; end
      if (la && ll) begin
        if (lb == 0) begin m_q.push_back(1); m_q.push_back(0); end
        else         begin m_q.push_back(0); m_q.push_back(1); end
      end else if (la) begin
        m_q.push_back(0);
      end else if (ll) begin
        m_q.push_back(1);
      end
      if (both && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endfunction

  task automatic check_all();
    int g;
    g = model_head();
    check_val("we",     128'(we),     128'(m_we));
    check_val("addr",   128'(waddr),  128'(m_out.addr));
    check_val("data",   128'(wdata),  128'(m_out.data));
    check_val("elems",  128'(welems), 128'(m_out.elems));
    check_val("widen",  128'(wwiden), 128'(m_out.widen));
    check_val("a_rdy",  128'(a_rdy),  128'(!m_full[0] || g == 0));
    check_val("l_rdy",  128'(l_rdy),  128'(!m_full[1] || g == 1));
    check_val("idle",   128'(idle),   128'(!m_full[0] && !m_full[1] && !m_we));
    check_val("cnt",    128'(cnt),    128'(m_cnt));
    if (we === 1'b1) rf[waddr] = wdata;
  endtask

  task automatic idle_inputs();
    a_v   = 1'b0;
    l_v   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    model_reset();
    @(negedge clk);
    check_all();
    reset = 1'b0;
  endtask

  logic [127:0] d_l, d_a;
  logic [4:0]   prev_addr;
  bit           pa_low, pl_low, seen;
  int           pa, pl;

  initial begin
    total = 0;
    bad   = 0;
    a_req = '0;
    l_req = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    do_reset();
    check_val("rst_rdy", 128'({a_rdy, l_rdy, idle}), 128'(3'b111));

    // Single ARITH request: write visible two cycles later, for one cycle.
    a_v = 1'b1; a_req = rand_req(5'd3); a_req.data = {16{8'hA5}}; a_req.elems = 2'd2;
    tick();
    a_v = 1'b0;
    check_val("t1_c2_we", 128'(we), 128'(0));
    tick();
    check_val("t1_c3_we", 128'(we), 128'(1));
    check_val("t1_c3_addr", 128'(waddr), 128'(3));
    check_val("t1_c3_data", wdata, {16{8'hA5}});
    tick();
    check_val("t1_c4_we", 128'(we), 128'(0));
    check_val("t1_c4_idle", 128'(idle), 128'(1));

    // Simultaneous requests after reset: ARITH first, then LSU.
    do_reset();
    a_v = 1'b1; a_req = rand_req(5'd4);
    l_v = 1'b1; l_req = rand_req(5'd7);
    tick();
    idle_inputs();
    tick();
    check_val("t2_c3_addr", 128'({we, waddr}), 128'({1'b1, 5'd4}));
    tick();
    check_val("t2_c4_addr", 128'({we, waddr}), 128'({1'b1, 5'd7}));
    check_val("t2_cnt", 128'(cnt), 128'(1));

    // Same destination from both sources: final register value is ARITH data.
    do_reset();
    l_v = 1'b1; l_req = rand_req(5'd5); d_l = 128'(l_req.data);
    tick();
    l_v = 1'b0;
    a_v = 1'b1; a_req = rand_req(5'd5); d_a = 128'(a_req.data);
    tick();
    a_v = 1'b0;
    check_val("t3_first", wdata, d_l);
    tick();
    check_val("t3_second", wdata, d_a);
    tick();
    check_val("t3_vd5", rf[5], d_a);

    // Continuous load: unbroken writes, alternating sources, ready never low twice running.
    do_reset();
    pa_low = 1'b0; pl_low = 1'b0; prev_addr = 5'd0;
    for (int i = 0; i < 8; i++) begin
      a_v = 1'b1; a_req = rand_req(5'd1);
      l_v = 1'b1; l_req = rand_req(5'd2);
      tick();
      if (i >= 1) begin
        check_val("t4_we", 128'(we), 128'(1));
        if (i >= 2) check_val("t4_alt", 128'(waddr != prev_addr), 128'(1));
        prev_addr = waddr;
      end
      check_val("t4_a_rdy2", 128'(pa_low && !a_rdy), 128'(0));
      check_val("t4_l_rdy2", 128'(pl_low && !l_rdy), 128'(0));
      pa_low = !a_rdy;
      pl_low = !l_rdy;
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();

    // Flush with both slots full: nothing written afterwards.
    do_reset();
    a_v = 1'b1; a_req = rand_req(5'd8);
    l_v = 1'b1; l_req = rand_req(5'd9);
    tick();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("t5_we", 128'(we), 128'(0));
    check_val("t5_rdy_idle", 128'({a_rdy, l_rdy, idle}), 128'(3'b111));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t5_no_stale", 128'(we), 128'(0));
    end

    // Asynchronous reset while a write is on the port.
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      a_v = ($urandom_range(0, 99) < 70); a_req = rand_req(5'($urandom_range(0, 31)));
      l_v = ($urandom_range(0, 99) < 70); l_req = rand_req(5'($urandom_range(0, 31)));
      tick();
      seen = (we === 1'b1);
    end
    check_val("t6_we_seen", 128'(seen), 128'(1));
    reset = 1'b1;
    idle_inputs();
    #1;
    check_val("t6_async_we", 128'(we), 128'(0));
    check_val("t6_async_out", 128'({waddr, wdata, welems, wwiden}), 128'(0));
    check_val("t6_async_cnt", 128'(cnt), 128'(0));
    check_val("t6_async_idle", 128'(idle), 128'(1));
    @(posedge clk);
    model_reset();
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // Randomized traffic with varying load and occasional flushes.
    for (int seg = 0; seg < 6; seg++) begin
      pa = $urandom_range(10, 100);
      pl = $urandom_range(10, 100);
      for (int i = 0; i < 400; i++) begin
        a_v   = ($urandom_range(0, 99) < pa);
        l_v   = ($urandom_range(0, 99) < pl);
        flush = ($urandom_range(0, 99) < 3);
        a_req = rand_req(5'($urandom_range(0, 31)));
        l_req = rand_req(5'($urandom_range(0, 31)));
        tick();
      end
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();
    check_val("end_idle", 128'(idle), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
